// File: rtl/free_list_pkg.sv
// -----------------------------------------------------------------------------
// free_list_pkg
// Shared rename-path definitions for the physical-register free list.
//   PHYS_REG_SZ  : total physical registers
//   ARCH_REGS    : architectural registers (tags 0..ARCH_REGS-1 are mapped at reset)
//   FL_DEPTH     : free list capacity, must be a power of two
//   PHYS_REG_IDX : physical register tag
//   FL_PTR       : extended free-list pointer (index + wrap bit); the branch
//                  stack checkpoint packet stores one of these
// -----------------------------------------------------------------------------
package free_list_pkg;

    localparam int PHYS_REG_SZ = 64;
    localparam int ARCH_REGS   = 32;
    localparam int FL_DEPTH    = PHYS_REG_SZ - ARCH_REGS;
    localparam int FL_LOG      = $clog2(FL_DEPTH);
    localparam int PHYS_IDX_W  = $clog2(PHYS_REG_SZ);

    typedef logic [PHYS_IDX_W-1:0] PHYS_REG_IDX;
    typedef logic [FL_LOG:0]       FL_PTR;

    // Entry index addressed by an extended pointer (wrap bit dropped).
    function automatic logic [FL_LOG-1:0] fl_index(input FL_PTR p);
        return p[FL_LOG-1:0];
    endfunction

endpackage

// File: rtl/free_list_lane_compact.sv
// -----------------------------------------------------------------------------
// free_list_lane_compact
// N-way valid-lane compaction. For every lane, offset_o gives the number of
// valid lanes below it, i.e. the slot the lane lands in when valid lanes are
// packed in lane order. count_o is the popcount of valid_i.
//   valid_i  : per-lane valid
//   offset_o : N packed offsets, lane i at [i*CW +: CW]
//   count_o  : number of valid lanes
// -----------------------------------------------------------------------------
module free_list_lane_compact #(
    parameter int N  = 3,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]    valid_i,
    output logic [N*CW-1:0] offset_o,
    output logic [CW-1:0]   count_o
);

    logic [CW-1:0] acc;

    always_comb begin
        offset_o = '0;
        acc      = '0;
        for (int i = 0; i < N; i++) begin
            offset_o[i*CW +: CW] = acc;
            acc                  = acc + CW'(valid_i[i]);
        end
        count_o = acc;
    end

endmodule

// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
// N-way circular free list of physical register tags for the rename path.
// Head supplies up to N tags per cycle to dispatch; tail reclaims up to N
// retired t_old tags per cycle. The extended head is exported for branch
// checkpoints and restored on mispredict.
//   clock, reset : clock, synchronous active-high reset
//   num_alloc    : tags consumed by dispatch this cycle (<= num_avail)
//   alloc_t      : lane i = entries[head+i], valid for i < num_avail
//   num_avail    : min(N, count), pre-update
//   free_valid   : per-lane retire-free enable
//   free_t       : retired tag per lane; tag 0 is never reclaimed
//   br_en        : mispredict recovery, head <= br_head
//   br_head      : checkpointed extended head
//   out_head     : extended head after this cycle's update
//   empty        : count == 0, pre-update
//   debug_*      : DEBUG builds only, raw state
// -----------------------------------------------------------------------------
module free_list
    import free_list_pkg::*;
#(
    parameter  int N  = 3,
    localparam int CW = $clog2(N + 1),
    localparam int TW = PHYS_IDX_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CW-1:0]     num_alloc,
    output logic [N*TW-1:0]   alloc_t,
    output logic [CW-1:0]     num_avail,
    input  logic [N-1:0]      free_valid,
    input  logic [N*TW-1:0]   free_t,
    input  logic              br_en,
    input  logic [FL_LOG:0]   br_head,
    output logic [FL_LOG:0]   out_head,
    output logic              empty
`ifdef DEBUG
    ,
    output logic [FL_DEPTH*TW-1:0] debug_entries,
    output logic [FL_LOG:0]        debug_head,
    output logic [FL_LOG:0]        debug_tail,
    output logic [FL_LOG:0]        debug_count
`endif
);

    PHYS_REG_IDX   entries_q [FL_DEPTH];
    FL_PTR         head_q, head_d;
    FL_PTR         tail_q, tail_d;
    FL_PTR         count;

    logic [N-1:0]    keep;
    logic [N*CW-1:0] wr_off;
    logic [CW-1:0]   free_cnt;

    // Extended-width subtraction keeps full (DEPTH) and empty (0) distinct.
    assign count = tail_q - head_q;
    assign empty = (count == '0);

    always_comb begin
        if (count >= FL_PTR'(N)) begin
            num_avail = CW'(N);
        end else begin
            num_avail = count[CW-1:0];
        end
    end

    // Tag 0 is the hardwired zero register and must never enter the list.
    always_comb begin
        keep = '0;
        for (int i = 0; i < N; i++) begin
            keep[i] = free_valid[i] && (free_t[i*TW +: TW] != '0);
        end
    end

    free_list_lane_compact #(
        .N  (N),
        .CW (CW)
    ) u_compact (
        .valid_i  (keep),
        .offset_o (wr_off),
        .count_o  (free_cnt)
    );

    // Combinational read at head; freed tags land in entries_q at the edge,
    // so there is no same-cycle bypass.
    for (genvar g = 0; g < N; g++) begin : g_alloc
        assign alloc_t[g*TW +: TW] = entries_q[fl_index(head_q + FL_PTR'(g))];
    end

    always_comb begin
        head_d = head_q + FL_PTR'(num_alloc);
        if (br_en) begin
            head_d = br_head;
        end
        tail_d = tail_q + FL_PTR'(free_cnt);
    end

    assign out_head = head_d;

    // Entries are never cleared on allocation, so a recovered head sees the
    // same tags it handed out after the checkpoint.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= FL_PTR'(FL_DEPTH);
            for (int i = 0; i < FL_DEPTH; i++) begin
                entries_q[i] <= PHYS_REG_IDX'(ARCH_REGS + i);
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int i = 0; i < N; i++) begin
                if (keep[i]) begin
                    entries_q[fl_index(tail_q + FL_PTR'(wr_off[i*CW +: CW]))] <= free_t[i*TW +: TW];
                end
            end
        end
    end

`ifdef DEBUG
    for (genvar g = 0; g < FL_DEPTH; g++) begin : g_dbg
        assign debug_entries[g*TW +: TW] = entries_q[g];
    end
    assign debug_head  = head_q;
    assign debug_tail  = tail_q;
    assign debug_count = count;
`endif

`ifndef DC
    FL_PTR br_dist;
    int    count_next;

    // br_head must lie in [tail-DEPTH, head]: distance back from head bounded
    // by the slots that are not currently free.
    assign br_dist = head_q - br_head;

    always_comb begin
        if (br_en) begin
            count_next = int'(count) + int'(br_dist) + int'(free_cnt);
        end else begin
            count_next = int'(count) + int'(free_cnt) - int'(num_alloc);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (!br_en) begin
                assert (num_alloc <= num_avail)
                    else $error("free_list: num_alloc %0d exceeds num_avail %0d", num_alloc, num_avail);
            end else begin
                assert (int'(br_dist) <= FL_DEPTH - int'(count))
                    else $error("free_list: br_head %0d outside live window", br_head);
            end
            assert (count_next <= FL_DEPTH)
                else $error("free_list: overflow, next count %0d", count_next);
        end
    end
`endif

endmodule
